// File: rtl/hft_tx_pkg.sv
// Shared types and sizing for the order-register transmit path.
// Frame geometry is fixed here so the FIFO entry and the stream mux agree.
package hft_tx_pkg;

  localparam int unsigned REG_WIDTH  = 32;
  localparam int unsigned NUM_WORDS  = 9;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CNT_WIDTH  = 16;

  localparam int unsigned IDX_WIDTH  = $clog2(NUM_WORDS);
  localparam int unsigned FRAME_W    = NUM_WORDS * REG_WIDTH;
  localparam int unsigned ENTRY_W    = 2 * FRAME_W;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_WORDS - 1);

  localparam logic SIDE_BUY  = 1'b0;
  localparam logic SIDE_SELL = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_BUY  = 2'd1,
    SEND_SELL = 2'd2
  } tx_state_t;

endpackage

// File: rtl/order_tx_fifo.sv
// First-word-fall-through frame FIFO; a full FIFO still accepts a push on a popping edge.
// head_nxt_o presents the entry that will be at the head after the current edge.
module order_tx_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             push_acc_o,
  output logic [WIDTH-1:0] head_nxt_o,
  output logic             empty_nxt_o,
  output logic             full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q;
  logic             full_now;
  logic             pop_ok;
  logic             push_ok;
  logic             bypass;

  always_comb begin
    full_now = (count_q == CNT_W'(DEPTH));
    pop_ok   = pop_i && (count_q != '0);
    push_ok  = push_i && (!full_now || pop_ok);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    // Incoming frame becomes the head when nothing older will remain stored.
    bypass   = (count_q == '0) || (pop_ok && (count_q == CNT_W'(1)));
  end

  assign push_acc_o  = push_ok;
  assign head_nxt_o  = bypass ? data_i : mem_q[rd_ptr_d];
  assign empty_nxt_o = (count_d == '0);
  assign full_o      = full_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/order_tx_serializer.sv
// Buffers buy/sell register frame pairs and streams them as 32-bit words, buy side first.
// Stream outputs are registered from next-state values so a pushed frame appears one cycle later.
module order_tx_serializer
  import hft_tx_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic [FRAME_W-1:0]   i_buy_words,
  input  logic [FRAME_W-1:0]   i_sell_words,
  input  logic                 i_tx_ready,
  output logic                 o_tx_valid,
  output logic [REG_WIDTH-1:0] o_tx_data,
  output logic                 o_tx_last,
  output logic                 o_tx_side,
  output logic                 o_full,
  output logic [CNT_WIDTH-1:0] o_drop_count
);

  tx_state_t              state_q, state_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic                   valid_q, valid_d;
  logic [REG_WIDTH-1:0]   data_q, data_d;
  logic                   last_q, last_d;
  logic                   side_q, side_d;
  logic [CNT_WIDTH-1:0]   drop_q, drop_d;

  logic                   beat;
  logic                   pop;
  logic                   push_acc;
  logic                   empty_nxt;
  logic [ENTRY_W-1:0]     head_nxt;
  logic [FRAME_W-1:0]     sel_words;

  assign beat = valid_q && i_tx_ready;
  assign pop  = beat && (state_q == SEND_SELL) && (idx_q == LAST_IDX);

  order_tx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (i_clk),
    .rst_i       (i_reset),
    .push_i      (i_valid),
    .data_i      ({i_sell_words, i_buy_words}),
    .pop_i       (pop),
    .push_acc_o  (push_acc),
    .head_nxt_o  (head_nxt),
    .empty_nxt_o (empty_nxt),
    .full_o      (o_full)
  );

  // Next-state: word index advances only on accepted beats.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (!empty_nxt) begin
          state_d = SEND_BUY;
          idx_d   = '0;
        end
      end
      SEND_BUY: begin
        if (beat) begin
          if (idx_q == LAST_IDX) begin
            state_d = SEND_SELL;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_WIDTH'(1);
          end
        end
      end
      SEND_SELL: begin
        if (beat) begin
          if (idx_q == LAST_IDX) begin
            state_d = empty_nxt ? IDLE : SEND_BUY;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    sel_words = (state_d == SEND_SELL) ? head_nxt[ENTRY_W-1:FRAME_W] : head_nxt[FRAME_W-1:0];
    valid_d   = (state_d != IDLE);
    data_d    = valid_d ? sel_words[32'(idx_d) * REG_WIDTH +: REG_WIDTH] : '0;
    last_d    = valid_d && (idx_d == LAST_IDX);
    side_d    = valid_d && (state_d == SEND_SELL) ? SIDE_SELL : SIDE_BUY;
    drop_d    = drop_q;
    if (i_valid && !push_acc && (drop_q != '1)) begin
      drop_d = drop_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      side_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      side_q  <= side_d;
      drop_q  <= drop_d;
    end
  end

  assign o_tx_valid   = valid_q;
  assign o_tx_data    = data_q;
  assign o_tx_last    = last_q;
  assign o_tx_side    = side_q;
  assign o_drop_count = drop_q;

endmodule
